// File: rtl/online_otf_converter_pkg.sv
// Shared definitions for the online multiplier back end.
// Holds the redundant digit encoding used by the digit-selection stage
// and by the on-the-fly converter, plus the converter FSM state encoding.
package online_otf_converter_pkg;

  localparam logic [1:0] DIG_POS  = 2'b10;
  localparam logic [1:0] DIG_NEG  = 2'b01;
  localparam logic [1:0] DIG_ZERO = 2'b00;
  localparam logic [1:0] DIG_ILL  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SKIP = 2'd1,
    ST_CONV = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  function automatic logic digit_illegal(input logic [1:0] d);
    return d == DIG_ILL;
  endfunction

endpackage

// File: rtl/online_otf_converter_if.sv
// Digit/result bundle of the on-the-fly converter.
//   master : digit source side (drives enable, start, p_value)
//   slave  : converter side (drives result, busy, done, digit_err, digit_cnt)
interface online_otf_converter_if #(
  parameter int DIGITS    = 8,
  parameter int CNT_WIDTH = 5
);
  logic                  enable;
  logic                  start;
  logic [1:0]            p_value;
  logic signed [DIGITS:0] result;
  logic                  busy;
  logic                  done;
  logic                  digit_err;
  logic [CNT_WIDTH-1:0]  digit_cnt;

  modport master (
    output enable, start, p_value,
    input  result, busy, done, digit_err, digit_cnt
  );

  modport slave (
    input  enable, start, p_value,
    output result, busy, done, digit_err, digit_cnt
  );
endinterface

// File: rtl/online_otf_converter_otf_qqm_reg.sv
// Q/QM on-the-fly conversion register pair.
// Ports:
//   clk, reset : clock and synchronous active-high reset (clears Q and QM)
//   load       : initialise Q = 0, QM = -1 for a new word
//   shift      : append one signed digit to both registers
//   digit      : redundant digit (+1 / 0 / -1, illegal code treated as 0)
//   q_next     : Q value after this cycle's update (used to capture result)
module otf_qqm_reg
  import online_otf_converter_pkg::*;
#(
  parameter int W = 9
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic                shift,
  input  logic [1:0]          digit,
  output logic signed [W-1:0] q_next
);

  logic signed [W-1:0] q_q, q_d;
  logic signed [W-1:0] qm_q, qm_d;

  // QM always tracks Q - ulp, so a -1 digit reuses QM instead of borrowing.
  always_comb begin
    q_d  = q_q;
    qm_d = qm_q;
    if (load) begin
      q_d  = '0;
      qm_d = '1;
    end else if (shift) begin
      case (digit)
        DIG_POS: begin
          q_d  = {q_q[W-2:0], 1'b1};
          qm_d = {q_q[W-2:0], 1'b0};
        end
        DIG_NEG: begin
          q_d  = {qm_q[W-2:0], 1'b1};
          qm_d = {qm_q[W-2:0], 1'b0};
        end
        default: begin
          q_d  = {q_q[W-2:0], 1'b0};
          qm_d = {qm_q[W-2:0], 1'b1};
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_q  <= '0;
      qm_q <= '0;
    end else begin
      q_q  <= q_d;
      qm_q <= qm_d;
    end
  end

  assign q_next = q_d;

endmodule

// File: rtl/online_otf_converter.sv
// On-the-fly converter: turns a stream of redundant signed product digits
// into a two's-complement fraction (result = fraction * 2^DIGITS).
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   bus        : slave side of online_otf_converter_if
//                (enable/start/p_value in; result/busy/done/digit_err/digit_cnt out)
module online_otf_converter
  import online_otf_converter_pkg::*;
#(
  parameter int DIGITS       = 8,
  parameter int ONLINE_DELAY = 2,
  parameter int CNT_WIDTH    = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  online_otf_converter_if.slave  bus
);

  localparam int W = DIGITS + 1;
  // Counter values on the last warm-up digit and on the last converted digit.
  localparam logic [CNT_WIDTH-1:0] SKIP_LAST =
    CNT_WIDTH'((ONLINE_DELAY > 0) ? ONLINE_DELAY - 1 : 0);
  localparam logic [CNT_WIDTH-1:0] CONV_LAST =
    CNT_WIDTH'(ONLINE_DELAY + DIGITS - 1);

  state_e                state_q, state_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  err_q, err_d;
  logic signed [W-1:0]   result_q, result_d;
  logic                  load, shift;
  logic signed [W-1:0]   q_next;

  otf_qqm_reg #(.W(W)) u_qqm (
    .clk    (clk),
    .reset  (reset),
    .load   (load),
    .shift  (shift),
    .digit  (bus.p_value),
    .q_next (q_next)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    result_d = result_q;
    load     = 1'b0;
    shift    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          load    = 1'b1;
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = (ONLINE_DELAY == 0) ? ST_CONV : ST_SKIP;
        end
      end
      ST_SKIP: begin
        if (bus.enable) begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
          if (cnt_q == SKIP_LAST) state_d = ST_CONV;
        end
      end
      ST_CONV: begin
        if (bus.enable) begin
          shift = 1'b1;
          cnt_d = cnt_q + CNT_WIDTH'(1);
          if (digit_illegal(bus.p_value)) err_d = 1'b1;
          if (cnt_q == CONV_LAST) begin
            state_d  = ST_DONE;
            result_d = q_next;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      result_q <= result_d;
    end
  end

  assign bus.result    = result_q;
  assign bus.busy      = (state_q == ST_SKIP) || (state_q == ST_CONV);
  assign bus.done      = (state_q == ST_DONE);
  assign bus.digit_err = err_q;
  assign bus.digit_cnt = cnt_q;

endmodule
